// File: rtl/game_flow_controller_if.sv
// rtl/game_flow_controller_if.sv - game event inputs and sequencing outputs of the game flow controller (optional GAME_FLOW_GOD_MODE_EN adds GodMode)
interface game_flow_controller_if;
  logic       startOfFrame;
  logic       startKey;
  logic       aliensReachedBorder;
  logic       playerHitByAlienPulse;
  logic [2:0] playerHitByRocket;
  logic       allAliensDead;
`ifdef GAME_FLOW_GOD_MODE_EN
  logic       GodMode;
`endif
  logic [2:0] state;
  logic [2:0] livesLeft;
  logic [2:0] level;
  logic       gameActive;
  logic       levelLoad;
  logic       playerRespawn;

  // Environment side: drives game events, observes sequencing controls
  modport master (
`ifdef GAME_FLOW_GOD_MODE_EN
    output GodMode,
`endif
    output startOfFrame, startKey, aliensReachedBorder, playerHitByAlienPulse,
    output playerHitByRocket, allAliensDead,
    input  state, livesLeft, level, gameActive, levelLoad, playerRespawn
  );

  // Controller side
  modport slave (
`ifdef GAME_FLOW_GOD_MODE_EN
    input  GodMode,
`endif
    input  startOfFrame, startKey, aliensReachedBorder, playerHitByAlienPulse,
    input  playerHitByRocket, allAliensDead,
    output state, livesLeft, level, gameActive, levelLoad, playerRespawn
  );
endinterface

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - Space Invaders game sequencer: lives, level, phase; GAME_FLOW_GOD_MODE_EN enables GodMode
module game_flow_controller #(
  parameter int LIVES               = 3,
  parameter int RESPAWN_FRAMES      = 60,
  parameter int INTERMISSION_FRAMES = 120,
  parameter int MAX_LEVEL           = 4
) (
  input logic                    clk,
  input logic                    reset,
  game_flow_controller_if.slave  gf
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PLAYING     = 3'd1;
  localparam logic [2:0] S_HIT         = 3'd2;
  localparam logic [2:0] S_LEVEL_CLEAR = 3'd3;
  localparam logic [2:0] S_GAME_OVER   = 3'd4;
  localparam logic [2:0] S_WIN         = 3'd5;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [7:0] RESP_LAST  = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] INTER_LAST = 8'(INTERMISSION_FRAMES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic [7:0] frame_q, frame_d;
  logic       hit_prev_q, start_prev_q;
  logic       active_q, active_d;
  logic       load_q, load_d;
  logic       resp_q, resp_d;

  logic hit_edge, start_edge, god;

  assign hit_edge   = (gf.playerHitByRocket != 3'd0) && !hit_prev_q;
  assign start_edge = gf.startKey && !start_prev_q;

`ifdef GAME_FLOW_GOD_MODE_EN
  assign god = gf.GodMode;
`else
  assign god = 1'b0;
`endif

  // State and counter registers; edge detectors track their inputs in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lives_q      <= LIVES_INIT;
      level_q      <= 3'd1;
      frame_q      <= 8'd0;
      hit_prev_q   <= 1'b0;
      // Sampling the key during reset makes a key held through reset look
      // already pressed, so only a fresh press afterwards starts a game.
      start_prev_q <= gf.startKey;
      active_q     <= 1'b0;
      load_q       <= 1'b0;
      resp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      frame_q      <= frame_d;
      hit_prev_q   <= gf.playerHitByRocket != 3'd0;
      start_prev_q <= gf.startKey;
      active_q     <= active_d;
      load_q       <= load_d;
      resp_q       <= resp_d;
    end
  end

  // Next phase, lives, level and frame counter from prioritised game events
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (start_edge) begin
          state_d = S_PLAYING;
          lives_d = LIVES_INIT;
          level_d = 3'd1;
        end
      end
      S_PLAYING: begin
        if (gf.aliensReachedBorder || (gf.playerHitByAlienPulse && !god)) begin
          state_d = S_GAME_OVER;
          lives_d = 3'd0;
        end else if (hit_edge && !god) begin
          if (lives_q <= 3'd1) begin
            state_d = S_GAME_OVER;
            lives_d = 3'd0;
          end else begin
            state_d = S_HIT;
            lives_d = lives_q - 3'd1;
            frame_d = 8'd0;
          end
        end else if (gf.allAliensDead) begin
          state_d = S_LEVEL_CLEAR;
          frame_d = 8'd0;
        end
      end
      S_HIT: begin
        if (gf.startOfFrame) begin
          if (frame_q == RESP_LAST) begin
            state_d = S_PLAYING;
            frame_d = 8'd0;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      S_LEVEL_CLEAR: begin
        if (gf.startOfFrame) begin
          if (frame_q == INTER_LAST) begin
            frame_d = 8'd0;
            if (level_q >= LEVEL_MAX) begin
              state_d = S_WIN;
            end else begin
              state_d = S_PLAYING;
              level_d = level_q + 3'd1;
            end
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs derived from the phase transition being taken this cycle
  always_comb begin
    active_d = (state_d == S_PLAYING);
    load_d   = (state_d == S_PLAYING) && (state_q != S_PLAYING) && (state_q != S_HIT);
    resp_d   = (state_d == S_PLAYING) && ((state_q == S_HIT) || (state_q == S_LEVEL_CLEAR));
  end

  assign gf.state         = state_q;
  assign gf.livesLeft     = lives_q;
  assign gf.level         = level_q;
  assign gf.gameActive    = active_q;
  assign gf.levelLoad     = load_q;
  assign gf.playerRespawn = resp_q;

endmodule
